mem_ctrl_lsu: RTL

//  Parametrised load/store unit between execute stage and data memory: computes effective address, drives word-aligned bus

---
 rtl/mem_ctrl_lsu.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl_lsu.sv
// Load/store unit: effective address, lane strobes, misaligned split into two beats, sign/zero-extended loads.
// Latency 2 cycles aligned / 3 split plus one per mem_ready wait cycle; enable ignored while busy, beats time out after TIMEOUT_CYCLES.
module mem_ctrl_lsu #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int SPLIT_MISALIGNED = 1,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                is_store_i,
    input  logic [1:0]          size_i,
    input  logic                is_unsigned_i,
    input  logic [XLEN-1:0]     op1_i,
    input  logic [11:0]         offset_i,
    input  logic [XLEN-1:0]     op3_i,
    output logic                busy_o,
    output logic [XLEN-1:0]     result_o,
    output logic                result_valid_o,
    output logic                fault_o,
    output logic                bus_error_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_enable_o,
    output logic                write_enable_o,
    output logic [XLEN/8-1:0]   byte_enables_o,
    output logic [XLEN-1:0]     write_data_o,
    input  logic [XLEN-1:0]     read_data_i,
    input  logic                mem_ready_i
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, FLT, ACC0, ACC1, RESP} state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [LB-1:0]       lane_q;
    logic [1:0]          size_q;
    logic                st_q, uns_q, cross_q;
    logic [NB-1:0]       be_hi_q;
    logic [XLEN-1:0]     wd_hi_q, ld_q;
    logic                busy_q, result_valid_q, fault_q, bus_error_q;
    logic                read_enable_q, write_enable_q;
    logic [XLEN-1:0]     result_q, write_data_q;
    logic [ADDR_W-1:0]   address_q;
    logic [NB-1:0]       byte_enables_q;

    logic [ADDR_W-1:0]   ea_d;
    logic [LB-1:0]       lane_d;
    int                  nbytes_d;
    logic                illegal_d, misal_d, cross_d;
    logic [XLEN-1:0]     op3_m;
    logic [2*NB-1:0]     be_d;
    logic [2*XLEN-1:0]   wd_d;
    logic [LB+3:0]       sh1_d;
    logic [XLEN-1:0]     ld_d;
    logic                acc_done_d, acc_tout_d;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] sz,
                                               input logic uns);
        logic [XLEN-1:0] r;
        logic            fill;
        int              nb;
        nb = 1 << sz;
        if (nb > NB) nb = NB;
        fill = d[8*nb-1] & ~uns;
        r = '0;
        for (int i = 0; i < NB; i++)
            r[8*i +: 8] = (i < nb) ? d[8*i +: 8] : {8{fill}};
        return r;
    endfunction

    always_comb begin
        ea_d      = ADDR_W'(op1_i) + ADDR_W'($signed(offset_i));
        lane_d    = ea_d[LB-1:0];
        nbytes_d  = 1 << size_i;
        illegal_d = (size_i == 2'b11) && (XLEN != 64);
        misal_d   = (int'(lane_d) % nbytes_d) != 0;
        cross_d   = (int'(lane_d) + nbytes_d) > NB;
        op3_m     = '0;
        be_d      = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < nbytes_d) begin
                op3_m[8*i +: 8] = op3_i[8*i +: 8];
                be_d[i]         = 1'b1;
            end
        end
        be_d = be_d << lane_d;
        wd_d = {{XLEN{1'b0}}, op3_m} << {lane_d, 3'b000};
    end

    // Second beat brings the upper bytes; they land above the bytes gathered from beat 0.
    always_comb begin
        sh1_d      = {(LB+1)'(NB) - {1'b0, lane_q}, 3'b000};
        ld_d       = (state_q == ACC1) ? (ld_q | (read_data_i << sh1_d))
                                       : (read_data_i >> {lane_q, 3'b000});
        acc_done_d = mem_ready_i && !(state_q == ACC0 && cross_q);
        acc_tout_d = !mem_ready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            lane_q         <= '0;
            size_q         <= '0;
            st_q           <= 1'b0;
            uns_q          <= 1'b0;
            cross_q        <= 1'b0;
            be_hi_q        <= '0;
            wd_hi_q        <= '0;
            ld_q           <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            fault_q        <= 1'b0;
            bus_error_q    <= 1'b0;
            read_enable_q  <= 1'b0;
            write_enable_q <= 1'b0;
            result_q       <= '0;
            write_data_q   <= '0;
            address_q      <= '0;
            byte_enables_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (enable_i) begin
                    busy_q  <= 1'b1;
                    lane_q  <= lane_d;
                    size_q  <= size_i;
                    st_q    <= is_store_i;
                    uns_q   <= is_unsigned_i;
                    cross_q <= cross_d;
                    cnt_q   <= '0;
                    be_hi_q <= be_d[2*NB-1:NB];
                    wd_hi_q <= is_store_i ? wd_d[2*XLEN-1:XLEN] : '0;
                    // Rejected requests still take one extra cycle so every response lands at +2.
                    if (illegal_d || (misal_d && SPLIT_MISALIGNED == 0)) begin
                        state_q <= FLT;
                    end else begin
                        state_q        <= ACC0;
                        address_q      <= {ea_d[ADDR_W-1:LB], {LB{1'b0}}};
                        read_enable_q  <= !is_store_i;
                        write_enable_q <= is_store_i;
                        byte_enables_q <= be_d[NB-1:0];
                        write_data_q   <= is_store_i ? wd_d[XLEN-1:0] : '0;
                    end
                end
                FLT: begin
                    state_q        <= RESP;
                    result_valid_q <= 1'b1;
                    fault_q        <= 1'b1;
                end
                ACC0, ACC1: begin
                    if (mem_ready_i) begin
                        cnt_q <= '0;
                        ld_q  <= ld_d;
                    end else if (!acc_tout_d) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (acc_done_d || acc_tout_d) begin
                        state_q        <= RESP;
                        result_valid_q <= 1'b1;
                        bus_error_q    <= acc_tout_d;
                        result_q       <= (acc_done_d && !st_q) ? extend(ld_d, size_q, uns_q) : '0;
                        read_enable_q  <= 1'b0;
                        write_enable_q <= 1'b0;
                        byte_enables_q <= '0;
                        write_data_q   <= '0;
                        address_q      <= '0;
                    end else if (mem_ready_i) begin
                        state_q        <= ACC1;
                        address_q      <= address_q + ADDR_W'(NB);
                        byte_enables_q <= be_hi_q;
                        write_data_q   <= wd_hi_q;
                    end
                end
                RESP: begin
                    state_q        <= IDLE;
                    busy_q         <= 1'b0;
                    result_valid_q <= 1'b0;
                    fault_q        <= 1'b0;
                    bus_error_q    <= 1'b0;
                    result_q       <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign fault_o        = fault_q;
    assign bus_error_o    = bus_error_q;
    assign address_o      = address_q;
    assign read_enable_o  = read_enable_q;
    assign write_enable_o = write_enable_q;
    assign byte_enables_o = byte_enables_q;
    assign write_data_o   = write_data_q;
endmodule
